gcd_host: RTL and testbench
===========================

Name: gcd_host

Overview:
- Initiator side of the GCD operand interface (start / data_in / result / done). Converts a parallel operand-pair request into the serial GCD protocol.
- Waits for completion with a watchdog, then returns the result over a valid/ready response channel.
- Sits between a system-side requester and the GCD core, replacing bench-style stimulus in integrated designs.

Parameters:
- WIDTH, 8, operand/result width; must match the GCD core data width.
- TIMEOUT, 255, maximum cycles spent in WAIT before aborting; must be >= 1.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  operand pair offered.
- req_ready  out  1  host accepts a pair; high only in IDLE.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer ready.
- rsp_result  out  WIDTH  GCD value; 0 on timeout.
- rsp_timeout  out  1  response is an aborted transaction.
- gcd_start  out  1  GCD start level.
- gcd_data_in  out  WIDTH  serial operand bus to GCD.
- gcd_result  in  WIDTH  GCD result.
- gcd_done  in  1  GCD completion.

Behaviour:
- Reset, synchronous, active-high, overrides everything including mid-transaction:
  - state=IDLE, counters cleared.
  - req_ready=1 (IDLE), rsp_valid=0, rsp_result=0, rsp_timeout=0, gcd_start=0, gcd_data_in=0.
- States: IDLE, SEND_A, SEND_B, WAIT, RESP, RECOVER.
- IDLE:
  - On req_valid&&req_ready, register A and B.
  - If A==0 or B==0: rsp_result <= A|B (gcd(x,0)=x; gcd(0,0)=0), rsp_timeout <= 0, go to RESP. gcd_start is never asserted.
  - Else go to SEND_A.
- SEND_A: gcd_start=1, gcd_data_in=A for exactly one cycle. Go to SEND_B.
- SEND_B: gcd_start=1, gcd_data_in=B. Go to WAIT. B stays on gcd_data_in through WAIT.
- WAIT:
  - gcd_start stays 1. The watchdog counts from 0, incrementing each WAIT cycle.
  - gcd_done sampled 1: rsp_result <= gcd_result, rsp_timeout <= 0, go to RESP.
  - Else, if count == TIMEOUT-1: rsp_result <= 0, rsp_timeout <= 1, go to RESP.
  - If done and the timeout limit occur in the same cycle, done wins.
- RESP:
  - gcd_start=0, rsp_valid=1. rsp_result and rsp_timeout are stable until the handshake.
  - On rsp_valid&&rsp_ready: go to RECOVER if the GCD was used, else IDLE.
- RECOVER: one cycle, gcd_start=0, gcd_data_in=0. Guarantees start is low for at least one cycle before the next transaction. Go to IDLE.
- gcd_done is ignored in all states except WAIT.
- Latency, nonzero operands:
  - Accept at cycle t; A on the bus at t+1; B at t+2; WAIT from t+3.
  - done seen at cycle d gives rsp_valid at d+1.
  - Minimum next accept is 2 cycles after the response handshake.
- Latency, zero shortcut: rsp_valid at t+1.
- Watchdog width: $clog2(TIMEOUT+1).
- Outputs are registered. No combinational path from gcd_* inputs to rsp_*.

Decomposition:
- gcd_pkg holds:
  - host_state_e enum.
  - GCD_WIDTH default constant.
  - Helper function gcd_ref(a,b), used by the bench scoreboard only.
- No sub-module required. Watchdog and FSM stay in gcd_host, target ~150–200 RTL lines.

Test Plan:
- Nominal: req (143,78), rsp_ready=1, behavioural GCD core:
  - gcd_data_in=143 at t+1, 78 at t+2.
  - rsp_result=13, rsp_timeout=0.
  - gcd_start low for exactly one cycle in RECOVER.
- Zero shortcut:
  - req (0,45) → rsp_valid at t+1, rsp_result=45, gcd_start never 1.
  - req (0,0) → rsp_result=0.
- Backpressure: req (48,18), rsp_ready held 0 for 5 cycles after rsp_valid:
  - rsp_result=6 stable throughout; req_ready=0 throughout.
  - Completes the cycle rsp_ready rises.
- Timeout: TIMEOUT=16, core model never asserts done, req (9,6):
  - rsp_valid 16 cycles after WAIT entry.
  - rsp_timeout=1, rsp_result=0.
  - Next req (9,6) with a working core returns 3.
- Reset mid-WAIT: rst pulsed for 1 cycle during WAIT:
  - Next cycle gcd_start=0, rsp_valid=0, req_ready=1.
  - A late gcd_done is ignored.
- Back-to-back: (17,5) then (100,75) with req_valid held:
  - Results 1 then 25.
  - At least 1 cycle of gcd_start=0 between the two transactions.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD host/core pairing.
// gcd_ref is a behavioural reference used only by verification models.
package gcd_pkg;

    localparam int GCD_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND_A  = 3'd1,
        ST_SEND_B  = 3'd2,
        ST_WAIT    = 3'd3,
        ST_RESP    = 3'd4,
        ST_RECOVER = 3'd5
    } host_state_e;

    function automatic logic [31:0] gcd_ref(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] t;
        x = a;
        y = b;
        // Euclid on 32-bit values converges well within 48 steps.
        for (int i = 0; i < 48; i++) begin
            if (y != 0) begin
                t = x % y;
                x = y;
                y = t;
            end
        end
        return x;
    endfunction

endpackage

// File: rtl/gcd_host.sv
// Initiator for the serial GCD operand interface: takes a parallel operand pair,
// streams A then B to the core, waits for done under a watchdog, returns the result.
module gcd_host
    import gcd_pkg::*;
#(
    parameter int WIDTH   = GCD_WIDTH,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_timeout,
    output logic             gcd_start,
    output logic [WIDTH-1:0] gcd_data_in,
    input  logic [WIDTH-1:0] gcd_result,
    input  logic             gcd_done
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    host_state_e      state_q, state_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             used_q, used_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_timeout_q, rsp_timeout_d;
    logic             gcd_start_q, gcd_start_d;
    logic [WIDTH-1:0] gcd_data_in_q, gcd_data_in_d;

    always_comb begin
        state_d       = state_q;
        b_d           = b_q;
        wd_d          = wd_q;
        used_d        = used_q;
        req_ready_d   = req_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_result_d  = rsp_result_q;
        rsp_timeout_d = rsp_timeout_q;
        gcd_start_d   = gcd_start_q;
        gcd_data_in_d = gcd_data_in_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    b_d         = req_b;
                    req_ready_d = 1'b0;
                    // gcd(x,0)=x needs no core round trip.
                    if (req_a == '0 || req_b == '0) begin
                        used_d        = 1'b0;
                        rsp_result_d  = req_a | req_b;
                        rsp_timeout_d = 1'b0;
                        rsp_valid_d   = 1'b1;
                        state_d       = ST_RESP;
                    end else begin
                        used_d        = 1'b1;
                        gcd_start_d   = 1'b1;
                        gcd_data_in_d = req_a;
                        state_d       = ST_SEND_A;
                    end
                end
            end
            ST_SEND_A: begin
                gcd_data_in_d = b_q;
                state_d       = ST_SEND_B;
            end
            ST_SEND_B: begin
                wd_d    = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (gcd_done || wd_q == WD_LAST) begin
                    rsp_result_d  = gcd_done ? gcd_result : '0;
                    rsp_timeout_d = ~gcd_done;
                    rsp_valid_d   = 1'b1;
                    gcd_start_d   = 1'b0;
                    gcd_data_in_d = '0;
                    state_d       = ST_RESP;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (used_q) begin
                        state_d = ST_RECOVER;
                    end else begin
                        req_ready_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end
            ST_RECOVER: begin
                gcd_start_d   = 1'b0;
                gcd_data_in_d = '0;
                req_ready_d   = 1'b1;
                state_d       = ST_IDLE;
            end
            default: begin
                gcd_start_d   = 1'b0;
                gcd_data_in_d = '0;
                rsp_valid_d   = 1'b0;
                req_ready_d   = 1'b1;
                state_d       = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            b_q           <= '0;
            wd_q          <= '0;
            used_q        <= 1'b0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_timeout_q <= 1'b0;
            gcd_start_q   <= 1'b0;
            gcd_data_in_q <= '0;
        end else begin
            state_q       <= state_d;
            b_q           <= b_d;
            wd_q          <= wd_d;
            used_q        <= used_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_timeout_q <= rsp_timeout_d;
            gcd_start_q   <= gcd_start_d;
            gcd_data_in_q <= gcd_data_in_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_timeout = rsp_timeout_q;
    assign gcd_start   = gcd_start_q;
    assign gcd_data_in = gcd_data_in_q;

endmodule

// File: tb/tb_gcd_host.sv
// Directed bench for gcd_host with a behavioural serial GCD core model.
module tb_gcd_host;
    import gcd_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_timeout;
    logic       gcd_start;
    logic [7:0] gcd_data_in;
    logic [7:0] gcd_result;
    logic       gcd_done;

    int n_checks = 0;
    int n_fail   = 0;

    gcd_host #(.WIDTH(8), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_timeout(rsp_timeout),
        .gcd_start(gcd_start), .gcd_data_in(gcd_data_in),
        .gcd_result(gcd_result), .gcd_done(gcd_done)
    );

    always #5 clk = ~clk;

    // Core model: latches A on the first start cycle, B on the second, answers later.
    logic       core_en = 1'b1;
    logic       inj_done = 1'b0;
    logic       core_done = 1'b0;
    logic [7:0] core_res = 8'd0;
    logic [7:0] ca = 8'd0;
    logic [7:0] cb = 8'd0;
    int         cstate = 0;
    int         ccnt = 0;

    assign gcd_done   = core_done | inj_done;
    assign gcd_result = core_res;

    always @(posedge clk) begin
        if (!gcd_start) begin
            cstate    <= 0;
            core_done <= 1'b0;
        end else begin
            case (cstate)
                0: begin ca <= gcd_data_in; cstate <= 1; end
                1: begin cb <= gcd_data_in; cstate <= 2; ccnt <= 0; end
                2: if (core_en) begin
                    ccnt <= ccnt + 1;
                    if (ccnt == 3) begin
                        core_done <= 1'b1;
                        core_res  <= 8'(gcd_ref(32'(ca), 32'(cb)));
                        cstate    <= 3;
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Runs one request; called at a negedge, returns at a negedge.
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input int bp,
                           input logic [7:0] exp_res, input bit zero);
        int  n;
        int  lat;
        bit  saw_start;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        check("req_ready_before", req_ready, 1);
        req_valid = 1'b1; req_a = a; req_b = b;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        saw_start = 1'b0;
        if (!zero) begin
            check("bus_a", gcd_data_in, a);
            check("start_a", gcd_start, 1);
            @(negedge clk);
            lat = 2;
            check("bus_b", gcd_data_in, b);
        end
        while (!rsp_valid && lat < 200) begin
            if (gcd_start) saw_start = 1'b1;
            @(negedge clk);
            lat++;
        end
        check("rsp_valid_seen", rsp_valid, 1);
        if (zero) begin
            check("zero_latency", lat, 1);
            check("zero_no_start", saw_start, 0);
        end
        check("rsp_result", rsp_result, exp_res);
        check("rsp_timeout", rsp_timeout, 0);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check("bp_result", rsp_result, exp_res);
            check("bp_valid", rsp_valid, 1);
            check("bp_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("hs_valid_drop", rsp_valid, 0);
        if (zero) begin
            check("zero_back_idle", req_ready, 1);
        end else begin
            check("recover_ready", req_ready, 0);
            check("recover_start", gcd_start, 0);
            check("recover_bus", gcd_data_in, 0);
            @(negedge clk);
            check("idle_after_recover", req_ready, 1);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         bp;
        logic [7:0] res;
        bit         zero;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int  n;
        int  got;
        int  low_cnt;
        bit  restarted;

        vecs[0] = '{8'd143, 8'd78,  0, 8'd13,  1'b0};
        vecs[1] = '{8'd0,   8'd45,  0, 8'd45,  1'b1};
        vecs[2] = '{8'd0,   8'd0,   0, 8'd0,   1'b1};
        vecs[3] = '{8'd48,  8'd18,  5, 8'd6,   1'b0};
        vecs[4] = '{8'd45,  8'd0,   2, 8'd45,  1'b1};
        vecs[5] = '{8'd255, 8'd255, 0, 8'd255, 1'b0};
        vecs[6] = '{8'd1,   8'd200, 1, 8'd1,   1'b0};
        vecs[7] = '{8'd12,  8'd18,  0, 8'd6,   1'b0};

        rst = 1'b1; req_valid = 1'b0; req_a = 8'd0; req_b = 8'd0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        check("rst_gcd_start", gcd_start, 0);
        check("rst_gcd_data_in", gcd_data_in, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].a, vecs[i].b, vecs[i].bp, vecs[i].res, vecs[i].zero);
        end

        // Watchdog expiry with a silent core.
        core_en = 1'b0;
        req_valid = 1'b1; req_a = 8'd9; req_b = 8'd6;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        check("timeout_cycles", n, 16);
        check("timeout_flag", rsp_timeout, 1);
        check("timeout_result", rsp_result, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("timeout_recover", req_ready, 0);
        @(negedge clk);
        core_en = 1'b1;
        run_txn(8'd9, 8'd6, 0, 8'd3, 1'b0);

        // Reset in the middle of WAIT, then a stray done.
        core_en = 1'b0;
        req_valid = 1'b1; req_a = 8'd9; req_b = 8'd6;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("midwait_start", gcd_start, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_start", gcd_start, 0);
        check("mrst_rsp_valid", rsp_valid, 0);
        check("mrst_req_ready", req_ready, 1);
        inj_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("late_done_valid", rsp_valid, 0);
        check("late_done_ready", req_ready, 1);
        check("late_done_start", gcd_start, 0);
        inj_done = 1'b0;
        core_en = 1'b1;
        @(negedge clk);

        // Back-to-back with req_valid held high.
        req_valid = 1'b1; req_a = 8'd17; req_b = 8'd5; rsp_ready = 1'b1;
        got = 0; n = 0; low_cnt = 0; restarted = 1'b0;
        while (got < 2 && n < 300) begin
            @(negedge clk);
            n++;
            if (got == 1 && !restarted) begin
                if (!gcd_start) low_cnt++;
                else restarted = 1'b1;
            end
            if (rsp_valid) begin
                if (got == 0) begin
                    check("b2b_first", rsp_result, 1);
                    req_a = 8'd100; req_b = 8'd75;
                end else begin
                    check("b2b_second", rsp_result, 25);
                    req_valid = 1'b0;
                end
                got++;
            end
        end
        check("b2b_count", got, 2);
        check("b2b_start_gap", (low_cnt >= 1) ? 1 : 0, 1);
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
